// File: rtl/cdce_pkg.sv
// cdce_pkg: sequencer state encoding and default CDCE power-up timing shared with cdce_configure.
package cdce_pkg;

    typedef enum logic [2:0] {
        PDN_HOLD,
        SETTLE,
        CONFIG,
        SYNC_LO,
        SYNC_WAIT,
        LOCK_WAIT,
        READY
    } state_t;

    localparam int DEF_PDN_LOW_CYCLES      = 5000;
    localparam int DEF_SETTLE_CYCLES       = 25000;
    localparam int DEF_SYNC_LOW_CYCLES     = 50;
    localparam int DEF_SYNC_SETTLE_CYCLES  = 1000;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 2500000;
    localparam int DEF_CNT_W               = 24;

endpackage

// File: rtl/cdce_sync_2ff.sv
// cdce_sync_2ff: 1-bit two-flop synchronizer with asynchronous active-low reset.
module cdce_sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {q, meta} <= 2'b00;
        else          {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/cdce_power_sequencer.sv
// cdce_power_sequencer: CDCE pdn/device_sync power-up sequencing ahead of configuration.
// Define CDCE_PLL_LOCK_WAIT_EN to add the synchronized PLL lock wait and sticky lock_error.
module cdce_power_sequencer
    import cdce_pkg::*;
#(
    parameter int PDN_LOW_CYCLES      = DEF_PDN_LOW_CYCLES,
    parameter int SETTLE_CYCLES       = DEF_SETTLE_CYCLES,
    parameter int SYNC_LOW_CYCLES     = DEF_SYNC_LOW_CYCLES,
    parameter int SYNC_SETTLE_CYCLES  = DEF_SYNC_SETTLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic configure_done,
    input  logic pll_lock,
    output logic pdn,
    output logic device_sync,
    output logic config_enable,
    output logic ready,
    output logic lock_error
);

    localparam logic [CNT_W-1:0] PDN_N         = CNT_W'(PDN_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_N      = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_LOW_N    = CNT_W'(SYNC_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_SETTLE_N = CNT_W'(SYNC_SETTLE_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             pdn_d, sync_d, cfg_d, ready_d, err_d;

`ifdef CDCE_PLL_LOCK_WAIT_EN
    localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    logic lock_s;
    cdce_sync_2ff u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_lock),
        .q       (lock_s)
    );
`else
    logic unused_lock;
    assign unused_lock = pll_lock ^ (LOCK_TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt - CNT_W'(1);
        pdn_d   = pdn;
        sync_d  = device_sync;
        cfg_d   = config_enable;
        ready_d = ready;
        err_d   = lock_error;
        case (state)
            PDN_HOLD: if (cnt == '0) begin
                state_d = SETTLE;
                cnt_d   = SETTLE_N;
                pdn_d   = 1'b1;
            end
            SETTLE: if (cnt == '0) begin
                state_d = CONFIG;
                cfg_d   = 1'b1;
            end
            CONFIG: if (configure_done) begin
                state_d = SYNC_LO;
                cnt_d   = SYNC_LOW_N;
                sync_d  = 1'b0;
            end
            SYNC_LO: if (cnt == '0) begin
                state_d = SYNC_WAIT;
                cnt_d   = SYNC_SETTLE_N;
                sync_d  = 1'b1;
            end
            SYNC_WAIT: if (cnt == '0) begin
`ifdef CDCE_PLL_LOCK_WAIT_EN
                state_d = LOCK_WAIT;
                cnt_d   = LOCK_N;
`else
                state_d = READY;
                ready_d = 1'b1;
`endif
            end
`ifdef CDCE_PLL_LOCK_WAIT_EN
            // a timeout still releases ready, but flags the missing lock
            LOCK_WAIT: if (lock_s || cnt == '0) begin
                state_d = READY;
                ready_d = 1'b1;
                err_d   = !lock_s;
            end
            READY: if (!lock_s) err_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= PDN_HOLD;
            cnt           <= PDN_N;
            pdn           <= 1'b0;
            device_sync   <= 1'b1;
            config_enable <= 1'b0;
            ready         <= 1'b0;
            lock_error    <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            pdn           <= pdn_d;
            device_sync   <= sync_d;
            config_enable <= cfg_d;
            ready         <= ready_d;
            lock_error    <= err_d;
        end
    end

endmodule
